// File: rtl/q2_alu_seq_pkg.sv
// Shared opcodes, FSM states and initial-flag rule for the q2 serial ALU sequencer.
package q2_alu_seq_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_NOR  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SHR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // LOAD/NOR start the zero-detect chain at 1; ADD seeds the carry; SHR starts clear.
  function automatic logic init_flag(input logic [1:0] op, input logic carry_in);
    case (op)
      OP_LOAD, OP_NOR: init_flag = 1'b1;
      OP_ADD:          init_flag = carry_in;
      default:         init_flag = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/q2_alu_seq_shreg.sv
// WIDTH-bit parallel-load, shift-right register with serial input at the MSB.
module q2_alu_seq_shreg #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)        q <= '0;
    else if (load)  q <= d;
    else if (shift) q <= {sin, q[WIDTH-1:1]};
  end

endmodule

// File: rtl/q2_alu_seq.sv
// Word-level sequencer feeding the q2 1-bit ALU slice LSB-first for WIDTH cycles.
// Optional abort input is enabled by defining Q2_ALU_SEQ_ABORT_EN.
module q2_alu_seq
  import q2_alu_seq_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] x_in,
  input  logic             carry_in,
`ifdef Q2_ALU_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             flag_out,
  output logic             alu_a0,
  output logic             alu_x0,
  output logic             alu_x1,
  output logic             alu_f,
  output logic             alu_op3,
  output logic             alu_op4,
  input  logic             alu_out,
  input  logic             alu_cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [1:0]       op_q;
  logic             cin_q, f_q, shr_bit;
  logic [WIDTH-1:0] a_q, x_q;
  logic             running, accept, last_bit, abort_hit;
  logic             unused_x_hi;

  assign running  = (state == RUN);
  assign accept   = start && (state != RUN);
  assign last_bit = running && (count == LAST);
  assign busy     = running;
  assign done     = (state == DONE);

`ifdef Q2_ALU_SEQ_ABORT_EN
  assign abort_hit = running && abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Only the two low X bits reach the slice; the rest merely carry operand bits down.
  assign unused_x_hi = ^x_q[WIDTH-1:2];

  q2_alu_seq_shreg #(.WIDTH(WIDTH)) a_reg (
    .clk(clk), .rst(rst), .load(accept), .shift(running),
    .d(a_in), .sin(alu_out), .q(a_q)
  );

  q2_alu_seq_shreg #(.WIDTH(WIDTH)) x_reg (
    .clk(clk), .rst(rst), .load(accept), .shift(running),
    .d(x_in), .sin(1'b0), .q(x_q)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (abort_hit)          state_next = IDLE;
        else if (count == LAST) state_next = DONE;
      end
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_a0  = 1'b0;
    alu_x0  = 1'b0;
    alu_x1  = 1'b0;
    alu_f   = 1'b0;
    alu_op3 = 1'b0;
    alu_op4 = 1'b0;
    if (running) begin
      alu_a0  = a_q[0];
      alu_x0  = x_q[0];
      alu_x1  = (count == LAST) ? cin_q : x_q[1];
      alu_f   = f_q;
      alu_op3 = op_q[0];
      alu_op4 = op_q[1];
    end
  end

  // SHR reports the bit shifted out at bit 0, so it is kept apart from the running flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      op_q     <= OP_LOAD;
      cin_q    <= 1'b0;
      f_q      <= 1'b0;
      shr_bit  <= 1'b0;
      result   <= '0;
      flag_out <= 1'b0;
    end else if (accept) begin
      count <= '0;
      op_q  <= op;
      cin_q <= carry_in;
      f_q   <= init_flag(op, carry_in);
    end else if (running) begin
      count <= count + 1'b1;
      f_q   <= alu_cout;
      if (count == '0) shr_bit <= alu_cout;
      if (last_bit && !abort_hit) begin
        result   <= {alu_out, a_q[WIDTH-1:1]};
        flag_out <= (op_q == OP_SHR) ? shr_bit : alu_cout;
      end
    end
  end

endmodule
